fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the NibblER core; it sequences the PC (newaddr/loadPC/incPC) and reads the 8-bit ROM word at the current PC address.
- Decodes 2-byte jumps locally: unconditional, on carry, on zero. Redirects the PC without involving the execute unit.
- Hands all other instruction bytes to the execute unit over a valid/ready handshake.
- Stops permanently on HLT.

---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the NibblER core.
// Sequences the PC through incPC/loadPC/newaddr and reads one ROM byte
// per cycle. It resolves 2-byte jumps (JMP/JC/JZ) locally, hands every
// other byte to the execute unit over valid/ready, and stops forever on HLT.
// Optional build macro FETCH_SEQUENCER_SINGLE_STEP_EN adds a 'step' input
// that advances exactly one instruction from IDLE while run is low.
module fetch_sequencer #(
  parameter logic [3:0] JMP_OP = 4'h9,
  parameter logic [3:0] JC_OP  = 4'hA,
  parameter logic [3:0] JZ_OP  = 4'hB,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        run,
  input  logic [7:0]  rom_data,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic        ex_ready,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        incPC,
  output logic        loadPC,
  output logic [11:0] newaddr,
  output logic        instr_valid,
  output logic [7:0]  instr,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    FETCH_LO = 3'd2,
    ISSUE    = 3'd3,
    HALT     = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] ir_reg, ir_next;
  logic       oneshot_reg;
  logic       taken;
  state_t     resume_state;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  logic oneshot_next;

  // One-shot flag: set by a step pulse, cleared when its instruction retires.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) oneshot_reg <= 1'b0;
    else      oneshot_reg <= oneshot_next;
  end
`else
  assign oneshot_reg = 1'b0;
`endif

  // State and instruction register.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= IDLE;
      ir_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  // Branch decision uses the opcode latched in FETCH and the live flags.
  assign taken = (ir_reg[7:4] == JMP_OP) ||
                 ((ir_reg[7:4] == JC_OP) && flag_c) ||
                 ((ir_reg[7:4] == JZ_OP) && flag_z);

  // After a retired instruction a single-stepped run parks in IDLE.
  assign resume_state = oneshot_reg ? IDLE : FETCH;

  // Next-state and strobe decode.
  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    incPC       = 1'b0;
    loadPC      = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    oneshot_next = oneshot_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
        end
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        else if (step) begin
          state_next   = FETCH;
          oneshot_next = 1'b1;
        end
`endif
      end
      FETCH: begin
        // A stepped fetch must not be aborted by run being low.
        if (!run && !oneshot_reg) begin
          state_next = IDLE;
        end else begin
          ir_next = rom_data;
          incPC   = 1'b1;
          if (rom_data[7:4] == JMP_OP || rom_data[7:4] == JC_OP ||
              rom_data[7:4] == JZ_OP) begin
            state_next = FETCH_LO;
          end else if (rom_data[7:4] == HLT_OP) begin
            state_next = HALT;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
            oneshot_next = 1'b0;
`endif
          end else begin
            state_next = ISSUE;
          end
        end
      end
      FETCH_LO: begin
        if (taken) loadPC = 1'b1;
        else       incPC  = 1'b1;
        state_next = resume_state;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        oneshot_next = 1'b0;
`endif
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (ex_ready) begin
          state_next = resume_state;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
          oneshot_next = 1'b0;
`endif
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Jump target; forced to zero while reset is asserted.
  assign newaddr = Rst ? {ir_reg[3:0], rom_data} : 12'h000;
  assign instr   = ir_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table-driven check of fetch_sequencer
// against a ROM + PC model, plus hand sequences for reset/abort corners.
// Honors FETCH_SEQUENCER_SINGLE_STEP_EN when the design is built with it.
module tb_fetch_sequencer;

  logic        clk;
  logic        Rst;
  logic        run;
  logic [7:0]  rom_data;
  logic        flag_c;
  logic        flag_z;
  logic        ex_ready;
  logic        step;
  logic        incPC;
  logic        loadPC;
  logic [11:0] newaddr;
  logic        instr_valid;
  logic [7:0]  instr;
  logic        halted;

  fetch_sequencer dut (
    .clk(clk),
    .Rst(Rst),
    .run(run),
    .rom_data(rom_data),
    .flag_c(flag_c),
    .flag_z(flag_z),
    .ex_ready(ex_ready),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    .step(step),
`endif
    .incPC(incPC),
    .loadPC(loadPC),
    .newaddr(newaddr),
    .instr_valid(instr_valid),
    .instr(instr),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM and program counter model surrounding the sequencer
  logic [7:0]  rom [0:4095];
  logic [11:0] pc;
  assign rom_data = rom[pc];

  always @(posedge clk or negedge Rst) begin
    if (!Rst)        pc <= 12'h000;
    else if (loadPC) pc <= newaddr;
    else if (incPC)  pc <= pc + 12'h001;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // {incPC, loadPC, instr_valid, halted, instr}
  function automatic logic [11:0] outs();
    return {incPC, loadPC, instr_valid, halted, instr};
  endfunction

  typedef struct {
    bit        run;
    bit        exr;
    bit        fc;
    bit        fz;
    bit        inc;
    bit        ld;
    bit        iv;
    bit        hl;
    bit [7:0]  ins;
    bit [11:0] pc;
    bit [11:0] addr;
  } vec_t;

  vec_t vq[$];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; run = 1'b0; flag_c = 1'b0; flag_z = 1'b0;
    ex_ready = 1'b1; step = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h35;
    rom[12'h001] = 8'h91; rom[12'h002] = 8'h23;
    rom[12'h123] = 8'hA0; rom[12'h124] = 8'h40;
    rom[12'h125] = 8'hA0; rom[12'h126] = 8'h40;
    rom[12'h040] = 8'h77;
    rom[12'h041] = 8'hB1; rom[12'h042] = 8'h00;
    rom[12'h043] = 8'hB1; rom[12'h044] = 8'h50;
    rom[12'h150] = 8'hF0;

    //                run exr fc fz inc ld iv hl  instr   pc       addr
    vq.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h000}); // IDLE
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'h00, 12'h000, 12'h000}); // FETCH 35
    vq.push_back(vec_t'{1, 1, 0, 0, 0, 0, 1, 0, 8'h35, 12'h001, 12'h000}); // ISSUE
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'h35, 12'h001, 12'h000}); // FETCH 91
    vq.push_back(vec_t'{1, 1, 0, 0, 0, 1, 0, 0, 8'h91, 12'h002, 12'h123}); // JMP taken
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'h91, 12'h123, 12'h000}); // FETCH A0
    vq.push_back(vec_t'{1, 1, 0, 1, 1, 0, 0, 0, 8'hA0, 12'h124, 12'h000}); // JC not taken
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'hA0, 12'h125, 12'h000}); // FETCH A0
    vq.push_back(vec_t'{1, 1, 1, 0, 0, 1, 0, 0, 8'hA0, 12'h126, 12'h040}); // JC taken
    vq.push_back(vec_t'{1, 0, 0, 0, 1, 0, 0, 0, 8'hA0, 12'h040, 12'h000}); // FETCH 77
    vq.push_back(vec_t'{1, 0, 0, 0, 0, 0, 1, 0, 8'h77, 12'h041, 12'h000}); // stall 1
    vq.push_back(vec_t'{1, 0, 0, 0, 0, 0, 1, 0, 8'h77, 12'h041, 12'h000}); // stall 2
    vq.push_back(vec_t'{0, 0, 0, 0, 0, 0, 1, 0, 8'h77, 12'h041, 12'h000}); // stall 3, run ignored
    vq.push_back(vec_t'{1, 0, 0, 0, 0, 0, 1, 0, 8'h77, 12'h041, 12'h000}); // stall 4
    vq.push_back(vec_t'{1, 0, 0, 0, 0, 0, 1, 0, 8'h77, 12'h041, 12'h000}); // stall 5
    vq.push_back(vec_t'{1, 1, 0, 0, 0, 0, 1, 0, 8'h77, 12'h041, 12'h000}); // accepted
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'h77, 12'h041, 12'h000}); // FETCH B1
    vq.push_back(vec_t'{1, 1, 1, 0, 1, 0, 0, 0, 8'hB1, 12'h042, 12'h000}); // JZ not taken
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'hB1, 12'h043, 12'h000}); // FETCH B1
    vq.push_back(vec_t'{1, 1, 0, 1, 0, 1, 0, 0, 8'hB1, 12'h044, 12'h150}); // JZ taken
    vq.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 0, 8'hB1, 12'h150, 12'h000}); // FETCH F0
    vq.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1, 8'hF0, 12'h151, 12'h000}); // HALT
    vq.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 1, 8'hF0, 12'h151, 12'h000}); // HALT run=0
    vq.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1, 8'hF0, 12'h151, 12'h000}); // HALT run=1

    // Reset state
    #7;
    check("reset_outs", outs(), 12'h000);
    check("reset_newaddr", newaddr, 12'h000);
    next_cycle();
    Rst = 1'b1;

    // Main program, one row per cycle
    for (int i = 0; i < vq.size(); i++) begin
      run = vq[i].run; ex_ready = vq[i].exr; flag_c = vq[i].fc; flag_z = vq[i].fz;
      @(negedge clk);
      check($sformatf("vec%0d_outs", i), outs(),
            {vq[i].inc, vq[i].ld, vq[i].iv, vq[i].hl, vq[i].ins});
      check($sformatf("vec%0d_pc", i), pc, vq[i].pc);
      if (vq[i].ld) check($sformatf("vec%0d_newaddr", i), newaddr, vq[i].addr);
      $display("vec %0d pc=%h inc=%b ld=%b iv=%b instr=%h halted=%b",
               i, pc, incPC, loadPC, instr_valid, instr, halted);
      next_cycle();
    end

    // Reset while halted returns to a quiet IDLE
    Rst = 1'b0;
    #1;
    check("halt_rst_outs", outs(), 12'h000);
    check("halt_rst_newaddr", newaddr, 12'h000);
    next_cycle();
    run = 1'b0; Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("post_halt_idle%0d", i), outs(), 12'h000);
      $display("post-halt idle %0d pc=%h", i, pc);
      next_cycle();
    end
    check("post_halt_pc", pc, 12'h000);

    // run dropping in FETCH aborts without a strobe
    run = 1'b1;
    @(negedge clk);
    check("abort_idle", outs(), 12'h000);
    next_cycle();
    run = 1'b0;
    @(negedge clk);
    check("abort_fetch", outs(), 12'h000);
    next_cycle();
    @(negedge clk);
    check("abort_after", outs(), 12'h000);
    check("abort_pc", pc, 12'h000);
    $display("abort-in-fetch sequence pc=%h", pc);
    next_cycle();

    // Asynchronous reset in the middle of ISSUE
    run = 1'b1; ex_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("pre_rst_issue", outs(), {4'b0010, 8'h35});
    #2;
    Rst = 1'b0; run = 1'b0;
    #1;
    check("async_rst_valid", {11'h000, instr_valid}, 12'h000);
    check("async_rst_outs", outs(), 12'h000);
    next_cycle();
    Rst = 1'b1; ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_async_idle%0d", i), outs(), 12'h000);
      $display("post-async-reset idle %0d pc=%h", i, pc);
      next_cycle();
    end

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    // One step pulse with run low: exactly one issue, then IDLE
    begin
      int issues;
      issues = 0;
      step = 1'b1;
      @(negedge clk);
      check("step_idle", outs(), 12'h000);
      next_cycle();
      step = 1'b0;
      @(negedge clk);
      check("step_fetch", outs(), {4'b1000, 8'h00});
      next_cycle();
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (instr_valid) issues++;
        if (i == 0) check("step_issue", outs(), {4'b0010, 8'h35});
        else check($sformatf("step_after%0d", i), outs(), {4'b0000, 8'h35});
        next_cycle();
      end
      check("step_issue_count", issues[11:0], 12'h001);
      check("step_pc", pc, 12'h001);
      $display("single step issues=%0d pc=%h", issues, pc);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
